// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle of pipeline-side hazard/memory status signals and the
//                stall/flush/status outputs of pipe_ctrl.
//                master : pipeline datapath (drives status, consumes controls)
//                slave  : pipe_ctrl (consumes status, drives controls)
//  Signals     : decode_i_rs1/rs2(+_ren), regE_i_rd, regE_i_mem_ren,
//                execute_i_redirect, ifetch_i_valid, dmem_i_req,
//                dmem_i_ready, regW_i_commit -> controller
//                ctrl_o_stallF/D/E/M, ctrl_o_flushD/E/W, ctrl_o_state,
//                ctrl_o_mem_err, ctrl_o_cycle_cnt/instret_cnt/stall_cnt
//                <- controller
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0]  decode_i_rs1;
    logic [4:0]  decode_i_rs2;
    logic        decode_i_rs1_ren;
    logic        decode_i_rs2_ren;
    logic [4:0]  regE_i_rd;
    logic        regE_i_mem_ren;
    logic        execute_i_redirect;
    logic        ifetch_i_valid;
    logic        dmem_i_req;
    logic        dmem_i_ready;
    logic        regW_i_commit;

    logic        ctrl_o_stallF;
    logic        ctrl_o_stallD;
    logic        ctrl_o_stallE;
    logic        ctrl_o_stallM;
    logic        ctrl_o_flushD;
    logic        ctrl_o_flushE;
    logic        ctrl_o_flushW;
    logic [1:0]  ctrl_o_state;
    logic        ctrl_o_mem_err;
    logic [63:0] ctrl_o_cycle_cnt;
    logic [63:0] ctrl_o_instret_cnt;
    logic [63:0] ctrl_o_stall_cnt;

    modport master (
        output decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
               regE_i_rd, regE_i_mem_ren, execute_i_redirect, ifetch_i_valid,
               dmem_i_req, dmem_i_ready, regW_i_commit,
        input  ctrl_o_stallF, ctrl_o_stallD, ctrl_o_stallE, ctrl_o_stallM,
               ctrl_o_flushD, ctrl_o_flushE, ctrl_o_flushW, ctrl_o_state,
               ctrl_o_mem_err, ctrl_o_cycle_cnt, ctrl_o_instret_cnt,
               ctrl_o_stall_cnt
    );

    modport slave (
        input  decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
               regE_i_rd, regE_i_mem_ren, execute_i_redirect, ifetch_i_valid,
               dmem_i_req, dmem_i_ready, regW_i_commit,
        output ctrl_o_stallF, ctrl_o_stallD, ctrl_o_stallE, ctrl_o_stallM,
               ctrl_o_flushD, ctrl_o_flushE, ctrl_o_flushW, ctrl_o_state,
               ctrl_o_mem_err, ctrl_o_cycle_cnt, ctrl_o_instret_cnt,
               ctrl_o_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush sequencer for the five-stage pipeline.
//                Detects load-use hazards, squashes D/E on an execute
//                redirect, and freezes the pipeline (with bubbles into regW)
//                while a data-memory access is outstanding. A watchdog moves
//                the FSM to an absorbing ERR state if the access takes too
//                long.
//  Ports       : clk, rst (synchronous, active-high)
//                bus  : pipe_ctrl_if.slave (status in, stall/flush/status out)
//  Parameters  : MEM_TIMEOUT  max consecutive MEM_WAIT cycles (1..65535)
//  Options     : PIPE_CTRL_PERF_EN  builds cycle/instret/stall counters;
//                when undefined the counter ports read 0.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(MEM_TIMEOUT);

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_mem_err;

    logic w_wait_now;
    logic w_memstall;
    logic w_lu;
    logic w_stallF, w_stallD, w_stallE, w_stallM;
    logic w_flushD, w_flushE, w_flushW;

    assign w_wait_now = bus.dmem_i_req & ~bus.dmem_i_ready;

    // ERR freezes everything; otherwise only a genuinely outstanding access
    // stalls, so a same-cycle ready never costs a cycle.
    assign w_memstall = (r_state == ST_ERR) |
                        (((r_state == ST_RUN) | (r_state == ST_MEM_WAIT)) & w_wait_now);

    assign w_lu = bus.regE_i_mem_ren && (bus.regE_i_rd != 5'd0) &&
                  ((bus.decode_i_rs1_ren && (bus.decode_i_rs1 == bus.regE_i_rd)) ||
                   (bus.decode_i_rs2_ren && (bus.decode_i_rs2 == bus.regE_i_rd)));

    // Mealy control: memory freeze dominates, then redirect, load-use, fetch.
    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_flushW = 1'b0;
        if (!rst) begin
            if (w_memstall) begin
                // A redirect sitting in regE is held along with the stage and
                // is acted on once the freeze releases.
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_stallE = 1'b1;
                w_stallM = 1'b1;
                w_flushW = 1'b1;
            end else if (bus.execute_i_redirect) begin
                w_flushD = 1'b1;
                w_flushE = 1'b1;
            end else if (w_lu) begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_flushE = 1'b1;
            end else if (!bus.ifetch_i_valid) begin
                w_stallF = 1'b1;
                w_flushD = 1'b1;
            end
        end
    end

    // Wait FSM with watchdog. The counter saturates into ERR before it could
    // ever wrap, since MEM_TIMEOUT fits in 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wait_now) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_i_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (!bus.dmem_i_req) begin
                        // Request dropped without completion: abandon the wait.
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state   <= ST_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign bus.ctrl_o_stallF  = w_stallF;
    assign bus.ctrl_o_stallD  = w_stallD;
    assign bus.ctrl_o_stallE  = w_stallE;
    assign bus.ctrl_o_stallM  = w_stallM;
    assign bus.ctrl_o_flushD  = w_flushD;
    assign bus.ctrl_o_flushE  = w_flushE;
    assign bus.ctrl_o_flushW  = w_flushW;
    assign bus.ctrl_o_state   = r_state;
    assign bus.ctrl_o_mem_err = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;
    logic [63:0] r_stall_cnt;

    // Free-running 64-bit counters; natural wrap at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= 64'd0;
            r_instret_cnt <= 64'd0;
            r_stall_cnt   <= 64'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (bus.regW_i_commit) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
            if (w_stallF) begin
                r_stall_cnt <= r_stall_cnt + 64'd1;
            end
        end
    end

    assign bus.ctrl_o_cycle_cnt   = r_cycle_cnt;
    assign bus.ctrl_o_instret_cnt = r_instret_cnt;
    assign bus.ctrl_o_stall_cnt   = r_stall_cnt;
`else
    assign bus.ctrl_o_cycle_cnt   = 64'd0;
    assign bus.ctrl_o_instret_cnt = 64'd0;
    assign bus.ctrl_o_stall_cnt   = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Scoreboard bench for pipe_ctrl. The driver applies directed
//                and random stimulus, predicts each cycle's response from a
//                behavioural model and queues it; a monitor on the falling
//                edge pops and compares every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int c_TIMEOUT = 4;

    typedef struct {
        logic [6:0]  ctl;     // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
        logic [1:0]  state;
        logic        err;
        logic [63:0] cyc;
        logic [63:0] inst;
        logic [63:0] stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MEM_TIMEOUT(c_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: "mode" is a description of what the memory side is
    // doing, not a copy of the RTL encoding.
    int          m_mode;     // 0 running, 1 waiting on memory, 2 dead
    int          m_waited;   // wait cycles already spent
    longint unsigned m_cyc, m_inst, m_stl;

    function automatic logic [6:0] predict();
        bit outstanding;
        bit hazard;
        outstanding = bus.dmem_i_req && !bus.dmem_i_ready;
        hazard = bus.regE_i_mem_ren && bus.regE_i_rd != 0 &&
                 ((bus.decode_i_rs1_ren && bus.decode_i_rs1 == bus.regE_i_rd) ||
                  (bus.decode_i_rs2_ren && bus.decode_i_rs2 == bus.regE_i_rd));
        if (rst)                             return 7'b0000_000;
        if (m_mode == 2 || outstanding)      return 7'b1111_001;
        if (bus.execute_i_redirect)          return 7'b0000_110;
        if (hazard)                          return 7'b1100_010;
        if (!bus.ifetch_i_valid)             return 7'b1000_100;
        return 7'b0000_000;
    endfunction

    function automatic void advance(logic [6:0] ctl);
        bit outstanding;
        outstanding = bus.dmem_i_req && !bus.dmem_i_ready;
        if (rst) begin
            m_mode = 0; m_waited = 0;
            m_cyc = 0; m_inst = 0; m_stl = 0;
            return;
        end
`ifdef PIPE_CTRL_PERF_EN
        m_cyc++;
        if (bus.regW_i_commit) m_inst++;
        if (ctl[6]) m_stl++;
`endif
        if (m_mode == 0) begin
            if (outstanding) begin m_mode = 1; m_waited = 1; end
        end else if (m_mode == 1) begin
            if (!outstanding)                 begin m_mode = 0; m_waited = 0; end
            else if (m_waited >= c_TIMEOUT)   m_mode = 2;
            else                              m_waited++;
        end
    endfunction

    // One cycle: predict from current inputs, queue, then cross the edge.
    task automatic tick();
        exp_t e;
        e.ctl   = predict();
        e.state = 2'(m_mode);
        e.err   = (m_mode == 2);
        e.cyc   = m_cyc;
        e.inst  = m_inst;
        e.stl   = m_stl;
        q.push_back(e);
        @(posedge clk);
        advance(e.ctl);
        #1;
    endtask

    task automatic set_idle();
        bus.decode_i_rs1 = 5'd0;  bus.decode_i_rs2 = 5'd0;
        bus.decode_i_rs1_ren = 1'b0; bus.decode_i_rs2_ren = 1'b0;
        bus.regE_i_rd = 5'd0;     bus.regE_i_mem_ren = 1'b0;
        bus.execute_i_redirect = 1'b0; bus.ifetch_i_valid = 1'b1;
        bus.dmem_i_req = 1'b0;    bus.dmem_i_ready = 1'b0;
        bus.regW_i_commit = 1'b0;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare whenever a
    // prediction is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctl", {bus.ctrl_o_stallF, bus.ctrl_o_stallD, bus.ctrl_o_stallE,
                            bus.ctrl_o_stallM, bus.ctrl_o_flushD, bus.ctrl_o_flushE,
                            bus.ctrl_o_flushW}, 64'(e.ctl));
                chk("state", 64'(bus.ctrl_o_state), 64'(e.state));
                chk("mem_err", 64'(bus.ctrl_o_mem_err), 64'(e.err));
                chk("cycle_cnt", bus.ctrl_o_cycle_cnt, e.cyc);
                chk("instret_cnt", bus.ctrl_o_instret_cnt, e.inst);
                chk("stall_cnt", bus.ctrl_o_stall_cnt, e.stl);
            end
        end
    end

    initial begin
        set_idle();
        rst = 1'b1;
        m_mode = 0; m_waited = 0; m_cyc = 0; m_inst = 0; m_stl = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();                         // reset state, outputs held low
        bus.ifetch_i_valid = 1'b0;
        tick();                         // fetch stall suppressed in reset
        set_idle();
        rst = 1'b0;
        tick();

        // Load-use on rs1 with rd=5, then rd=0 (no hazard).
        bus.regE_i_mem_ren = 1'b1; bus.regE_i_rd = 5'd5;
        bus.decode_i_rs1 = 5'd5;   bus.decode_i_rs1_ren = 1'b1;
        tick();
        bus.regE_i_rd = 5'd0; bus.decode_i_rs1 = 5'd0;
        tick();
        // Load-use via rs2.
        bus.regE_i_rd = 5'd9; bus.decode_i_rs1_ren = 1'b0;
        bus.decode_i_rs2 = 5'd9; bus.decode_i_rs2_ren = 1'b1;
        tick();
        // Redirect together with load-use.
        bus.execute_i_redirect = 1'b1;
        tick();
        set_idle();
        tick();

        // Multi-cycle access with a concurrent redirect, ready 3 cycles later.
        bus.dmem_i_req = 1'b1; bus.execute_i_redirect = 1'b1;
        repeat (3) tick();
        bus.dmem_i_ready = 1'b1;
        tick();
        set_idle();
        // Single-cycle access.
        bus.dmem_i_req = 1'b1; bus.dmem_i_ready = 1'b1;
        tick();
        // Abort: request dropped while waiting.
        bus.dmem_i_ready = 1'b0;
        tick();
        bus.dmem_i_req = 1'b0;
        tick();
        // Fetch bubble.
        bus.ifetch_i_valid = 1'b0;
        tick();
        set_idle();

        // Watchdog: ready never comes, then ERR persists with inputs idle.
        bus.dmem_i_req = 1'b1;
        repeat (7) tick();
        set_idle();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Counter window: 10 cycles, 4 commits, 3 fetch stalls.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_idle();
            bus.regW_i_commit  = (i % 3 == 0);
            bus.ifetch_i_valid = !(i >= 4 && i < 7);
            tick();
        end
        set_idle();
        tick();

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.decode_i_rs1 = 5'($urandom_range(0, 3));
            bus.decode_i_rs2 = 5'($urandom_range(0, 3));
            bus.decode_i_rs1_ren = 1'($urandom_range(0, 1));
            bus.decode_i_rs2_ren = 1'($urandom_range(0, 1));
            bus.regE_i_rd = 5'($urandom_range(0, 3));
            bus.regE_i_mem_ren = 1'($urandom_range(0, 1));
            bus.execute_i_redirect = ($urandom_range(0, 5) == 0);
            bus.ifetch_i_valid = ($urandom_range(0, 4) != 0);
            bus.regW_i_commit = 1'($urandom_range(0, 1));
            if (bus.dmem_i_req) bus.dmem_i_req = ($urandom_range(0, 7) != 0);
            else                bus.dmem_i_req = ($urandom_range(0, 3) == 0);
            bus.dmem_i_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0;
        set_idle();

        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage RV64 pipeline (regF, regD, regE, regM, regW). It detects load-use hazards, squashes wrong-path instructions on an execute-stage redirect, and freezes the pipeline across multi-cycle data-memory accesses using a watchdog-guarded wait FSM. Its outputs drive the stall and flush inputs of every pipeline register. regW receives a bubble while the data-memory access is pending.

## Interface
- MEM_TIMEOUT, 255: max consecutive wait cycles in MEM_WAIT before entering ERR; legal range 1..65535.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- decode_i_rs1 / decode_i_rs2  in  5 each  source registers of the instruction in decode
- decode_i_rs1_ren / decode_i_rs2_ren  in  1 each  source actually read
- regE_i_rd  in  5  destination of the instruction in execute
- regE_i_mem_ren  in  1  instruction in execute is a load
- execute_i_redirect  in  1  taken branch/jump resolved in execute
- ifetch_i_valid  in  1  fetch response valid this cycle
- dmem_i_req  in  1  regM holds an active load/store
- dmem_i_ready  in  1  data memory completes the access this cycle
- regW_i_commit  in  1  instruction retiring
- ctrl_o_stallF, ctrl_o_stallD, ctrl_o_stallE, ctrl_o_stallM  out  1 each  hold the register
- ctrl_o_flushD, ctrl_o_flushE, ctrl_o_flushW  out  1 each  load a bubble (commit=0, reg_wen=0)
- ctrl_o_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
- ctrl_o_mem_err  out  1  sticky watchdog error
- ctrl_o_cycle_cnt, ctrl_o_instret_cnt, ctrl_o_stall_cnt  out  64 each  performance counters

## Operation
- The FSM is registered. Stall/flush outputs are combinational from the current state and the inputs (Mealy).
- Mem stall condition (memstall): state==ERR, or (state is RUN or MEM_WAIT) and dmem_i_req and !dmem_i_ready.
- memstall=1: stallF/D/E/M=1 and flushW=1. All other flushes are 0. Load-use, redirect and fetch handling are suppressed. A redirect held in regE is acted on after release.
- Load-use condition (lu): regE_i_mem_ren and regE_i_rd!=0 and ((rs1_ren and rs1==rd) or (rs2_ren and rs2==rd)).
- If memstall=0, outputs follow this priority:
  - redirect: flushD=1, flushE=1, and all stalls=0. Redirect overrides lu and fetch.
  - lu: stallF=1, stallD=1, flushE=1.
  - !ifetch_i_valid: stallF=1, flushD=1.
  - Otherwise all outputs are 0.
- FSM transitions:
  - RUN: if dmem_i_req and !dmem_i_ready, go to MEM_WAIT with wait counter=1. Otherwise stay in RUN.
  - MEM_WAIT, dmem_i_ready=1: go to RUN and clear the counter. Stalls drop in this same cycle.
  - MEM_WAIT, dmem_i_req=0: go to RUN. This is a protocol abort; no stall is applied.
  - MEM_WAIT, counter==MEM_TIMEOUT while still waiting: go to ERR.
  - MEM_WAIT otherwise: counter+1.
  - ERR: absorbing; only rst leaves it. ctrl_o_mem_err=1 in ERR.
- Wait counter is 16 bits and never wraps; ERR fires first.

## Timing
- Stall/flush response has zero-cycle latency: outputs change in the same cycle as the inputs.
- A single-cycle memory access (ready in the same cycle as req) causes no stall.
- An N-cycle access (ready N-1 cycles after req) stalls for exactly N-1 cycles and inserts N-1 bubbles into regW.
- A load-use hazard inserts exactly one bubble into E.
- A redirect squashes the 2 younger instructions (D, E).
- Reset values: state=RUN, counter=0, mem_err=0, all counters=0. While rst=1, all stall/flush outputs=0.
- rst in mid-MEM_WAIT or in ERR returns the FSM to RUN on the next edge.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on regW_i_commit.
  - stall_cnt increments on every cycle with ctrl_o_stallF=1.
  - All counters wrap at 2^64.
- Not defined: the counter registers are not built and the three ports are tied to 0.

## Test plan
- Load-use: regE load with rd=5, decode rs1=5, rs1_ren=1 → for 1 cycle stallF=1, stallD=1, flushE=1. With rd=0 → no stall.
- Redirect + lu in the same cycle → flushD=1, flushE=1, stallF=0, stallD=0.
- dmem_i_req held, ready asserted 3 cycles later → stallF/D/E/M=1 and flushW=1 for 3 cycles, state=1 for 3 cycles, then 0. A simultaneous redirect is ignored until release.
- MEM_TIMEOUT=4, ready never asserted → state=2 and mem_err=1 after 4 wait cycles, stalls held. rst → state=0, mem_err=0.
- ifetch_i_valid=0 with no hazard → stallF=1, flushD=1, others 0.
- PIPE_CTRL_PERF_EN: 10 cycles with 4 commits and 3 stall cycles → cycle_cnt=10, instret_cnt=4, stall_cnt=3. Without the macro, all three counters read 0.
